// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaled period counter,
// per-channel double-buffered duty, enable and polarity.
module pwm_multi_channel #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [ADDR_W-1:0] A_EN  = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] A_TOP = ADDR_W'(CHANNELS + 1);
  localparam logic [ADDR_W-1:0] A_PRE = ADDR_W'(CHANNELS + 2);
  localparam logic [ADDR_W-1:0] A_POL = ADDR_W'(CHANNELS + 3);

  logic [WIDTH-1:0]    r_duty_sh  [CHANNELS];
  logic [WIDTH-1:0]    r_duty_act [CHANNELS];
  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_pol;
  logic [WIDTH-1:0]    r_top;
  logic [WIDTH-1:0]    r_presc;
  logic [WIDTH-1:0]    r_presc_cnt;
  logic [WIDTH-1:0]    r_cnt;
  logic [CHANNELS-1:0] r_pwm;
  logic                r_ps;

  logic                w_tick;
  logic                w_wrap;
  logic [CHANNELS-1:0] w_pwm_nxt;

  assign w_tick = (r_presc_cnt >= r_presc);
  assign w_wrap = w_tick && (r_cnt >= r_top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= '0;
      r_pol   <= '0;
      r_top   <= '1;
      r_presc <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        (wr_addr == A_EN):  r_en    <= wr_data[CHANNELS-1:0];
        (wr_addr == A_TOP): r_top   <= wr_data;
        (wr_addr == A_PRE): r_presc <= wr_data;
        (wr_addr == A_POL): r_pol   <= wr_data[CHANNELS-1:0];
        default: ;
      endcase
    end
  end

  // Shadow is captured here; the active copy only moves on wrap,
  // so a write on the wrap edge lands one period later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i))
          r_duty_sh[i] <= wr_data;
        if (w_wrap)
          r_duty_act[i] <= r_duty_sh[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_tick)
        r_presc_cnt <= '0;
      else
        r_presc_cnt <= r_presc_cnt + WIDTH'(1);
      if (w_wrap)
        r_cnt <= '0;
      else if (w_tick)
        r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  always_comb begin
    w_pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_pwm_nxt[i] = (r_en[i] & (r_cnt < r_duty_act[i])) ^ r_pol[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
      r_ps  <= 1'b0;
    end else begin
      r_pwm <= w_pwm_nxt;
      r_ps  <= w_wrap;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_ps;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: cycle compare against a behavioural
// model plus directed duty/period measurements.
module tb_pwm_multi_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] pwm_out;
  logic       period_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(.CHANNELS(8), .WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm_out), .period_start(period_start)
  );

  // Behavioural model
  logic [7:0] m_sh [8];
  logic [7:0] m_act [8];
  logic [7:0] m_en, m_pol, m_top, m_presc, m_pc, m_cnt, m_pwm;
  logic       m_ps;
  wire        m_tick = (m_pc >= m_presc);
  wire        m_wrap = m_tick && (m_cnt >= m_top);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_sh[i]  <= 8'd0;
        m_act[i] <= 8'd0;
      end
      m_en <= 8'd0; m_pol <= 8'd0; m_top <= 8'hff; m_presc <= 8'd0;
      m_pc <= 8'd0; m_cnt <= 8'd0; m_pwm <= 8'd0; m_ps <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++)
        m_pwm[i] <= (m_en[i] && (m_cnt < m_act[i])) ^ m_pol[i];
      m_ps <= m_wrap;
      m_pc <= m_tick ? 8'd0 : m_pc + 8'd1;
      if (m_wrap) begin
        m_cnt <= 8'd0;
        for (int i = 0; i < 8; i++) m_act[i] <= m_sh[i];
      end else if (m_tick) begin
        m_cnt <= m_cnt + 8'd1;
      end
      if (wr_en) begin
        if (wr_addr < 4'd8) m_sh[wr_addr[2:0]] <= wr_data;
        else if (wr_addr == 4'd8)  m_en    <= wr_data;
        else if (wr_addr == 4'd9)  m_top   <= wr_data;
        else if (wr_addr == 4'd10) m_presc <= wr_data;
        else if (wr_addr == 4'd11) m_pol   <= wr_data;
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (pwm_out !== m_pwm || period_start !== m_ps) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t pwm=%b ps=%b required pwm=%b ps=%b",
               $time, pwm_out, period_start, m_pwm, m_ps);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (period_start) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_ps got=timeout required=pulse within %0d", bound);
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out[ch]);
    end
  endtask

  int hi, hi2, pos, acc;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", int'({period_start, pwm_out}), 0);
    rst_n = 1'b1;

    wr(4'd0, 8'd128);
    wr(4'd8, 8'h01);
    wait_ps(300);
    count_high(0, 256, hi);
    chk("duty128", hi, 128);
    chk("others_low", int'(pwm_out[7:1]), 0);

    wr(4'd0, 8'd0);
    wait_ps(300);
    count_high(0, 256, hi);
    chk("duty0", hi, 0);

    wr(4'd0, 8'd255);
    wait_ps(300);
    count_high(0, 256, hi);
    chk("duty255", hi, 255);

    wr(4'd0, 8'd200);
    wr(4'd9, 8'd99);
    wait_ps(300);
    count_high(0, 100, hi);
    chk("duty_gt_top", hi, 100);

    wr(4'd10, 8'd3);
    wr(4'd9, 8'd9);
    wr(4'd1, 8'd5);
    wr(4'd8, 8'h02);
    wait_ps(300);
    hi = 0; pos = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      hi += int'(pwm_out[1]);
      if (period_start && pos == 0) pos = i;
    end
    chk("presc_high", hi, 20);
    chk("presc_period", pos, 40);

    wr(4'd10, 8'd0);
    wr(4'd9, 8'd255);
    wr(4'd8, 8'h04);
    wr(4'd2, 8'd50);
    wait_ps(600);
    fork
      count_high(2, 256, hi);
      begin
        repeat (100) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'd10;
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    chk("duty_mid_old", hi, 50);
    fork
      count_high(2, 256, hi);
      begin
        repeat (255) @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'd30;
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    chk("duty_mid_new", hi, 10);
    count_high(2, 256, hi);
    count_high(2, 256, hi2);
    chk("wrap_edge_old", hi, 10);
    chk("wrap_edge_new", hi2, 30);

    wr(4'd8, 8'h00);
    wr(4'd11, 8'h08);
    repeat (2) @(negedge clk);
    chk("pol_idle", int'(pwm_out), 8'h08);
    wr(4'd3, 8'd64);
    wr(4'd8, 8'h08);
    wait_ps(300);
    count_high(3, 256, hi);
    chk("pol_active", hi, 192);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", int'({period_start, pwm_out}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    repeat (300) begin
      @(negedge clk);
      acc |= int'(pwm_out);
    end
    chk("post_reset_low", acc, 0);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = 8'($urandom);
        if (wr_addr == 4'd9 && $urandom_range(0, 1) == 1)
          wr_data = 8'($urandom_range(0, 40));
        if (wr_addr == 4'd10)
          wr_data = 8'($urandom_range(0, 3));
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator, the parametrised successor to the single-channel 8-bit PWM driven from the SPI register file. It generates CHANNELS independent PWM outputs from one shared period counter with a programmable prescaler and period. Each channel has its own double-buffered duty value, enable and polarity. The block sits behind the SPI peripheral's register write port and drives the `uo_out`/`uio_out` pins in the top-level wrapper.

## Interface

Parameters:
- `CHANNELS`, 8: number of PWM outputs (1..WIDTH).
- `WIDTH`, 8: width of the duty, period and prescale registers, and of the counters.
- `ADDR_W`, 4: write-address width; must satisfy 2^ADDR_W >= CHANNELS+4.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  register write strobe, one write per cycle in which it is high.
- `wr_addr`  in  ADDR_W  register address.
- `wr_data`  in  WIDTH  register write data.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_start`  out  1  one-cycle pulse marking the start of each period.

## Operation

Register map (writes only; unmapped addresses are ignored):
- `0..CHANNELS-1`: `duty_shadow[i]`. Reset value 0.
- `CHANNELS`: `en_mask`, taken from `wr_data[CHANNELS-1:0]`. Reset value 0.
- `CHANNELS+1`: `top`. The period is top+1 ticks. Reset value all ones.
- `CHANNELS+2`: `prescale`. One tick occurs every prescale+1 clocks. Reset value 0.
- `CHANNELS+3`: `pol_mask`, taken from `wr_data[CHANNELS-1:0]`. Reset value 0.

Prescaler:
- `presc_cnt` counts up from 0.
- When `presc_cnt >= prescale`, `tick` = 1 and `presc_cnt` is set to 0 on the next edge.

Period counter `cnt`:
- Advances only when `tick` = 1.
- On a tick with `cnt >= top` (the wrap condition), `cnt` is set to 0. Otherwise it increments.
- Using `>=` means that writing a `top` below the current `cnt` wraps at the next tick and never runs to 2^WIDTH.

Double buffering:
- On the wrap edge, `duty_act[i]` is loaded from `duty_shadow[i]` for every channel.
- A duty write therefore never produces a glitch mid-period.

Output function, evaluated on every clock:
- `pwm_out[i] <= (en_mask[i] & (cnt < duty_act[i])) ^ pol_mask[i]`.
- A disabled channel drives its idle level, which equals `pol_mask[i]`.
- `duty_act = 0` gives a constant inactive output.
- `duty_act > top` gives a constant active output.
- All comparisons are unsigned, WIDTH bits wide, with no extension.

Immediacy of register writes:
- `en_mask`, `pol_mask`, `top` and `prescale` take effect on the clock after the write.
- Only duty values are buffered.

## Timing

Reset:
- Reset is asynchronous.
- All registers, `presc_cnt`, `cnt` and `duty_act` go to their reset values.
- `pwm_out` = 0 and `period_start` = 0 during and after reset until the first update.
- After reset, a tick occurs every clock, the period is 2^WIDTH clocks, and all outputs stay low.

Write latency:
- A register is updated on the clock edge where `wr_en` = 1.

Output latency:
- `pwm_out` lags `cnt` by one clock: `cnt` = k in cycle n gives the corresponding output in cycle n+1.

`period_start`:
- Registered. It is high for exactly one clock, the first cycle in which `cnt` = 0 after a wrap.
- The first `pwm_out` value computed from the new `duty_act` appears in the cycle after the pulse.

Simultaneous events:
- If a `duty_shadow` write occurs on the wrap edge, the wrap loads the old shadow value. The new value is used from the following period.
- A `top` or `prescale` write on a tick edge is honoured from the next tick. The current edge uses the old value.
- If multiple writes target the same address in back-to-back cycles, the last write wins.

Reset mid-period:
- Outputs drop to 0 immediately, asynchronously.
- The counters restart from 0 when `rst_n` is released.

## Test plan

- Reset, then write duty0=128 and en_mask=0x01, with top=255 and prescale=0 → after the first `period_start`, `pwm_out[0]` is high for 128 clocks and low for 128 clocks, repeating; the other channels stay at 0.
- Write duty0=0 → constant low. Write duty0=255 with top=255 → 255 clocks high, 1 clock low. Write duty0=200 with top=99 → constant high.
- Write prescale=3 and top=9 with duty1=5 → period of 40 clocks with 20 clocks high; `period_start` is pulsed every 40 clocks.
- Write duty2 from 50 to 10 mid-period, with `en_mask` bit 2 set → the current period keeps 50 high clocks; the next period starts with 10. Repeat with the write landing exactly on the wrap edge → the 10 appears one period later.
- Set `pol_mask` = 0x08 with `en_mask` bit 3 = 0 → `pwm_out[3]` is constantly 1. Then enable it with duty3=64 and top=255 → 64 clocks low and 192 clocks high.
- Assert `rst_n` = 0 mid-period for 3 clocks → `pwm_out` and `period_start` go to 0 asynchronously and all registers return to their reset values; after release the outputs stay low until they are reprogrammed.
